// File: rtl/io_column_config_loader.sv
`default_nettype none
// ============================================================================
// io_column_config_loader : streams config words into a shadow register and
// commits the complete image atomically to the IO column. Rev 1.0
// ============================================================================
module io_column_config_loader #(
  parameter int CONFIG_WIDTH = 72,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   in_data,
  output logic                    busy,
  output logic                    done,
  output logic                    config_valid,
  output logic [CONFIG_WIDTH-1:0] config_out
);

  localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(NUM_WORDS - 1);

  generate
    if (CONFIG_WIDTH % WORD_WIDTH != 0) begin : g_bad_width
      $error("CONFIG_WIDTH must be an integer multiple of WORD_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_out_q, config_out_d;
  logic                    config_valid_q, config_valid_d;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      config_out_q   <= '0;
      config_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      config_out_q   <= config_out_d;
      config_valid_q <= config_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    config_out_d   = config_out_q;
    config_valid_d = config_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
          end
          // Counter holds on the last word so it can never wrap.
          if (cnt_q == C_LAST_WORD) state_d = S_COMMIT;
          else                      cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        config_out_d   = shadow_q;
        config_valid_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q == S_LOAD) || (state_q == S_COMMIT);
  assign done         = (state_q == S_DONE);
  assign config_valid = config_valid_q;
  assign config_out   = config_out_q;

endmodule
`default_nettype wire

// File: tb/tb_io_column_config_loader.sv
`default_nettype none
// ============================================================================
// tb_io_column_config_loader : directed self-checking bench, default and
// 24/4 parameter variant. Rev 1.0
// ============================================================================
module tb_io_column_config_loader;

  logic        clock = 1'b0;
  logic        nreset;
  logic        start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, busy, done, config_valid;
  logic [71:0] config_out;

  logic        v_start, v_in_valid;
  logic [3:0]  v_in_data;
  logic        v_in_ready, v_busy, v_done, v_config_valid;
  logic [23:0] v_config_out;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  io_column_config_loader dut (
    .clock(clock), .nreset(nreset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .config_valid(config_valid), .config_out(config_out)
  );

  io_column_config_loader #(.CONFIG_WIDTH(24), .WORD_WIDTH(4)) dut_v (
    .clock(clock), .nreset(nreset), .start(v_start), .in_valid(v_in_valid),
    .in_ready(v_in_ready), .in_data(v_in_data), .busy(v_busy), .done(v_done),
    .config_valid(v_config_valid), .config_out(v_config_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
  endtask

  // Waits gap cycles with in_valid low, then transfers one word.
  task automatic send_word(input logic [7:0] data, input int gap, input logic [71:0] hold_cfg);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
      check("gap_cfg_hold", config_out, hold_cfg);
    end
    check("word_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag, input logic [71:0] exp_cfg, input logic [71:0] old_cfg);
    check({tag, "_commit_busy"}, busy, 1);
    check({tag, "_commit_ready"}, in_ready, 0);
    check({tag, "_commit_cfg_old"}, config_out, old_cfg);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_cfg"}, config_out, exp_cfg);
    check({tag, "_cfg_valid"}, config_valid, 1);
    tick();
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_idle_ready"}, in_ready, 0);
  endtask

  initial begin
    int gaps[9] = '{0, 2, 5, 0, 1, 4, 0, 3, 0};

    nreset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    v_start = 1'b1; v_in_valid = 1'b1; v_in_data = 4'hF;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_valid", config_valid, 0);
    check("rst_cfg", config_out, 0);
    check("rst_v_busy", v_busy, 0);
    check("rst_v_cfg", v_config_out, 0);

    nreset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    v_start = 1'b0; v_in_valid = 1'b0; v_in_data = 4'h0;
    tick();
    check("idle_ready", in_ready, 0);

    // Basic load 0x01..0x09 with valid held.
    do_start();
    for (int k = 0; k < 9; k++) send_word(8'(k + 1), 0, 72'h0);
    finish_load("basic", 72'h090807060504030201, 72'h0);

    // Words offered while idle must not be captured.
    in_valid = 1'b1; in_data = 8'hEE;
    tick();
    check("idle_ignore_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;

    // Gapped load 0xA0..0xA8.
    do_start();
    for (int k = 0; k < 9; k++) send_word(8'(8'hA0 + k), gaps[k], 72'h090807060504030201);
    finish_load("gaps", 72'hA8A7A6A5A4A3A2A1A0, 72'h090807060504030201);

    // Reference image, then a partial reload with start pulses mid-load.
    do_start();
    for (int k = 0; k < 9; k++) send_word(8'(8'h11 + k), 0, 72'hA8A7A6A5A4A3A2A1A0);
    finish_load("ref", 72'h191817161514131211, 72'hA8A7A6A5A4A3A2A1A0);

    do_start();
    for (int k = 0; k < 4; k++) begin
      start = (k == 1 || k == 2);
      send_word(8'(8'hF1 + k), 0, 72'h191817161514131211);
      start = 1'b0;
    end
    for (int g = 0; g < 3; g++) tick();
    check("partial_cfg_hold", config_out, 72'h191817161514131211);
    check("partial_busy", busy, 1);
    check("partial_done", done, 0);
    check("partial_ready", in_ready, 1);

    // Fifth word, then reset mid-load.
    send_word(8'hF5, 0, 72'h191817161514131211);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    check("midrst_cfg", config_out, 0);
    check("midrst_cfg_valid", config_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_busy", busy, 0);

    do_start();
    for (int k = 0; k < 9; k++) send_word(8'(8'h21 + k), 0, 72'h0);
    finish_load("post_rst", 72'h292827262524232221, 72'h0);

    // Variant: 24-bit bus, 4-bit words; done after 8 edges from start.
    v_start = 1'b1;
    tick();
    v_start = 1'b0;
    check("v_ready", v_in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      v_in_valid = 1'b1;
      v_in_data  = 4'(k + 1);
      tick();
    end
    v_in_valid = 1'b0;
    check("v_commit_done", v_done, 0);
    check("v_commit_cfg", v_config_out, 0);
    tick();
    check("v_done", v_done, 1);
    check("v_cfg", v_config_out, 24'h654321);
    check("v_cfg_valid", v_config_valid, 1);
    tick();
    check("v_done_end", v_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
